core_mem_arb: RTL
=================

// Module: core_mem_arb
// PURPOSE
//  Two-to-one memory arbiter directly downstream of the core wrapper's
//  i_req/d_req ports. Merges the instruction and data channels onto one
//  split-transaction memory port (request, then later response) with one
//  transaction outstanding. Returns rdata and a one-cycle ack to the channel
//  that owns the transaction.
// PARAMETERS
//  MAX_D_BURST  4  consecutive data grants allowed while an instr request waits (1..15)
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   asynchronous active-low reset
//  i_req_val     in   1   instruction request valid (held until i_req_ack)
//  i_req_addr    in   32  instruction fetch address
//  i_req_ack     out  1   one-cycle completion pulse, instruction channel
//  i_ack_rdata   out  32  fetched word, valid while i_req_ack=1
//  d_req_val     in   1   data request valid (held until d_req_ack)
//  d_req_addr    in   32  data address
//  d_req_cop     in   3   {rsvd, nc, wr}
//  d_req_wdata   in   32  store data
//  d_req_size    in   3   3'b000 byte, 3'b010 half, 3'b100 word
//  d_req_ack     out  1   one-cycle completion pulse, data channel
//  d_ack_rdata   out  32  load data, valid while d_req_ack=1
//  m_req_val     out  1   memory request valid
//  m_req_rdy     in   1   memory accepts request when m_req_val & m_req_rdy
//  m_req_addr    out  32  memory address
//  m_req_cop     out  3   instr: 3'b000; data: d_req_cop unchanged
//  m_req_wdata   out  32  store data (zero for instr)
//  m_req_size    out  3   instr: 3'b100; data: d_req_size unchanged
//  m_resp_val    in   1   memory response valid (one cycle per transaction)
//  m_resp_rdata  in   32  response data
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; owner=instr; starvation count=0.
//  FSM IDLE: if d_req_val or i_req_val, pick a winner, latch its
//   addr/cop/wdata/size and the owner into registers, go REQ. Otherwise stay.
//  FSM REQ: m_req_val=1, driven from the latched fields. On m_req_rdy, go RESP.
//  FSM RESP: m_req_val=0. On m_resp_val, pulse the owner's ack in the same
//   cycle, with rdata=m_resp_rdata (combinational), then go IDLE.
//  Non-owner ack is always 0. rdata outputs are 0 when their ack is 0.
//  Minimum latency: grant cycle N, m_req_val at N+1, ack at N+2 if rdy and
//   resp are immediate. One idle cycle follows each ack.
//  Priority: data wins. A counter counts data grants while i_req_val=1. When
//   the count reaches MAX_D_BURST, the next grant goes to instr if it is
//   pending. The count clears on any instr grant.
//  Ignored conditions:
//   - m_resp_val in IDLE/REQ is dropped. This covers a stale response after reset.
//   - A val dropping after grant is ignored; the latched transaction completes.
//  Reset mid-transaction: immediate return to IDLE, outputs 0, no ack issued.
// CONFIGURATION
//  CORE_MEM_ARB_RR_EN defined: strict round-robin. When both channels are
//   pending, the grant goes to the channel not granted last. The starvation
//   counter and MAX_D_BURST are unused.
//  Not defined: data-priority arbitration with the MAX_D_BURST starvation guard.
// STRUCTURE
//  Package core_mem_pkg:
//   - COP_WR=0, COP_NC=1 bit indices
//   - SIZE_BYTE/HALF/WORD codes
//   - arb_state_t {IDLE, REQ, RESP}
//   - owner encoding OWN_I / OWN_D
//  Sub-module core_mem_arb_sel: combinational grant selection plus the
//   starvation counter (or, under the macro, the last-grant flag). Inputs:
//   both vals and the grant strobe. Output: winner.
// TESTING
//  1 Lone fetch 0x100, rdy=1, resp 1 cycle later with 0x00000013
//    -> m_req_addr=0x100, cop=000, size=100; i_req_ack at N+2, i_ack_rdata=0x13.
//  2 Store addr 0x2004, cop=001, size=010, wdata 0xBEEF, rdy delayed 3 cycles
//    -> m_req_val held 3 cycles with stable fields; then d_req_ack; i_req_ack stays 0.
//  3 Both vals held high, MAX_D_BURST=4, no RR -> grant order D,D,D,D,I,D,D,D,D,I.
//    With CORE_MEM_ARB_RR_EN -> D,I,D,I.
//  4 rst_n low during RESP, then m_resp_val after release
//    -> no ack, FSM IDLE, stale response dropped, next fetch served normally.
//  5 m_resp_val pulsed in REQ before acceptance -> ignored, no ack;
//    the later real response is acked.

Source files
------------

// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared definitions for the core memory arbiter.
//   COP_* : bit indices into the 3-bit {rsvd, nc, wr} operation field
//   SIZE_*: access size codes
//   arb_state_t: arbiter FSM states
//   owner_t: channel that owns the outstanding transaction
package core_mem_pkg;

    localparam int unsigned COP_WR = 0;
    localparam int unsigned COP_NC = 1;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b010;
    localparam logic [2:0] SIZE_WORD = 3'b100;

    localparam logic [2:0] INSTR_COP = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/core_mem_arb_sel.sv
// core_mem_arb_sel: grant selection for the core memory arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_val      : instruction request pending
//   d_val      : data request pending
//   grant      : strobe, a grant is taken this cycle using 'winner'
//   winner     : channel selected (combinational)
// Default: data priority; a counter of data grants taken while an instruction
// request waits forces an instruction grant once it reaches MAX_D_BURST.
// With CORE_MEM_ARB_RR_EN defined: strict round-robin between pending
// channels using a last-grant flag; the counter is not built.
module core_mem_arb_sel
    import core_mem_pkg::*;
#(
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_val,
    input  logic   d_val,
    input  logic   grant,
    output owner_t winner
);

`ifdef CORE_MEM_ARB_RR_EN

    owner_t last_grant;

    always_comb begin
        winner = OWN_I;
        if (i_val && d_val)
            winner = (last_grant == OWN_D) ? OWN_I : OWN_D;
        else if (d_val)
            winner = OWN_D;
    end

    // Reset value OWN_I makes the first contended grant go to data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= OWN_I;
        else if (grant)
            last_grant <= winner;
    end

`else

    localparam logic [3:0] BURST_LIM = 4'(MAX_D_BURST);

    logic [3:0] d_cnt;
    logic       starve;

    assign starve = i_val && (d_cnt >= BURST_LIM);

    always_comb begin
        winner = OWN_I;
        if (d_val && !starve)
            winner = OWN_D;
    end

    // Counts only data grants taken while instr waits; never exceeds the
    // limit because reaching it forces the next grant to instr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            d_cnt <= '0;
        else if (grant) begin
            if (winner == OWN_I)
                d_cnt <= '0;
            else if (i_val && (d_cnt < BURST_LIM))
                d_cnt <= d_cnt + 4'd1;
        end
    end

`endif

endmodule

// File: rtl/core_mem_arb.sv
// core_mem_arb: two-to-one arbiter merging the instruction and data channels
// onto one split-transaction memory port, one transaction outstanding.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_req_val/addr             : instruction request (held until i_req_ack)
//   i_req_ack, i_ack_rdata     : instruction completion pulse and data
//   d_req_val/addr/cop/wdata/size : data request (held until d_req_ack)
//   d_req_ack, d_ack_rdata     : data completion pulse and data
//   m_req_val/rdy/addr/cop/wdata/size : memory request handshake
//   m_resp_val, m_resp_rdata   : memory response, one cycle per transaction
// Parameter MAX_D_BURST (1..15): data grants allowed while instr waits.
// Macro CORE_MEM_ARB_RR_EN selects round-robin arbitration instead.
module core_mem_arb
    import core_mem_pkg::*;
#(
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_val,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ack,
    output logic [31:0] i_ack_rdata,
    input  logic        d_req_val,
    input  logic [31:0] d_req_addr,
    input  logic [2:0]  d_req_cop,
    input  logic [31:0] d_req_wdata,
    input  logic [2:0]  d_req_size,
    output logic        d_req_ack,
    output logic [31:0] d_ack_rdata,
    output logic        m_req_val,
    input  logic        m_req_rdy,
    output logic [31:0] m_req_addr,
    output logic [2:0]  m_req_cop,
    output logic [31:0] m_req_wdata,
    output logic [2:0]  m_req_size,
    input  logic        m_resp_val,
    input  logic [31:0] m_resp_rdata
);

    arb_state_t state;
    owner_t     owner;
    owner_t     winner;
    logic       grant;
    logic       resp_hit;

    assign grant = (state == IDLE) && (i_req_val || d_req_val);

    core_mem_arb_sel #(
        .MAX_D_BURST(MAX_D_BURST)
    ) u_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .i_val (i_req_val),
        .d_val (d_req_val),
        .grant (grant),
        .winner(winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= OWN_I;
            m_req_val   <= 1'b0;
            m_req_addr  <= '0;
            m_req_cop   <= '0;
            m_req_wdata <= '0;
            m_req_size  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner     <= winner;
                        m_req_val <= 1'b1;
                        if (winner == OWN_D) begin
                            m_req_addr  <= d_req_addr;
                            m_req_cop   <= d_req_cop;
                            m_req_wdata <= d_req_wdata;
                            m_req_size  <= d_req_size;
                        end else begin
                            m_req_addr  <= i_req_addr;
                            m_req_cop   <= INSTR_COP;
                            m_req_wdata <= '0;
                            m_req_size  <= SIZE_WORD;
                        end
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (m_req_rdy) begin
                        m_req_val <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (m_resp_val)
                        state <= IDLE;
                end
                default: begin
                    m_req_val <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Responses outside RESP never reach the channels.
    assign resp_hit    = (state == RESP) && m_resp_val;
    assign i_req_ack   = resp_hit && (owner == OWN_I);
    assign d_req_ack   = resp_hit && (owner == OWN_D);
    assign i_ack_rdata = i_req_ack ? m_resp_rdata : '0;
    assign d_ack_rdata = d_req_ack ? m_resp_rdata : '0;

endmodule
